// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register serializer: FSM state codes and
// the width helpers used to size its counters.
package sr_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/sr_tx_ctrl_if.sv
// Producer-side handshake plus serial/status outputs of the serializer.
interface sr_tx_ctrl_if #(
  parameter int unsigned WIDTH = 5
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             so;
  logic             frame;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, so, frame, busy, done
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, so, frame, busy, done
  );

endinterface

// File: rtl/sr_bit_tick.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last clock
// of each bit period. DIV=1 ticks every enabled clock with the count held at 0.
module sr_bit_tick
  import sr_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned       CNT_W    = cnt_width(DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    tick_c = en && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sr_tx_ctrl.sv
// Serializer controller: accepts a word on a valid/ready handshake, shifts it
// out MSB-first holding each bit DIV clocks, then pulses done for one cycle.
module sr_tx_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DIV   = 4
) (
  input logic         clk,
  input logic         rst,
  sr_tx_ctrl_if.slave bus
);

  localparam int unsigned      BIT_W    = clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;

  logic tick_c;
  logic accept_c;
  logic last_bit_c;
  logic div_en_c;
  logic div_clr_c;

  // Divider runs only in SHIFT; abort or any other state holds it cleared.
  always_comb begin
    accept_c   = (state_q == ST_IDLE) && bus.in_valid && !bus.abort;
    last_bit_c = tick_c && (bitcnt_q == BIT_LAST);
    div_en_c   = (state_q == ST_SHIFT);
    div_clr_c  = bus.abort || (state_q != ST_SHIFT);
  end

  sr_bit_tick #(
    .DIV (DIV)
  ) u_bit_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr_c),
    .en     (div_en_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Next-state logic; abort wins over every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.abort)       state_d = ST_IDLE;
        else if (last_bit_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shift register and bit counter; both are zero whenever IDLE is entered.
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) shreg_d = bus.in_data;
        bitcnt_d = '0;
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          shreg_d  = '0;
          bitcnt_d = '0;
        end else if (tick_c) begin
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = last_bit_c ? '0 : bitcnt_q + BIT_W'(1);
        end
      end
      default: begin
        shreg_d  = '0;
        bitcnt_d = '0;
      end
    endcase
  end

  // Outputs decode the state flops; only in_ready sees abort directly.
  always_comb begin
    bus.frame    = (state_q == ST_SHIFT);
    bus.busy     = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    bus.done     = (state_q == ST_DONE);
    bus.so       = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
    bus.in_ready = (state_q == ST_IDLE) && !bus.abort;
  end

endmodule

// File: tb/tb_sr_tx_ctrl.sv
// Bench for sr_tx_ctrl: two instances (DIV=2, DIV=1) checked every cycle
// against a cycle-count model, with accepted words scoreboarded to done.
module tb_sr_tx_ctrl;

  localparam int unsigned W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] drv_data [2];
  logic [1:0]   drv_valid = '0;
  logic [1:0]   drv_abort = '0;

  logic [1:0] obs_so, obs_frame, obs_busy, obs_done, obs_ready;

  sr_tx_ctrl_if #(.WIDTH(W)) bus0 ();
  sr_tx_ctrl_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_data  = drv_data[0];
  assign bus0.in_valid = drv_valid[0];
  assign bus0.abort    = drv_abort[0];
  assign bus1.in_data  = drv_data[1];
  assign bus1.in_valid = drv_valid[1];
  assign bus1.abort    = drv_abort[1];

  assign obs_so    = {bus1.so,       bus0.so};
  assign obs_frame = {bus1.frame,    bus0.frame};
  assign obs_busy  = {bus1.busy,     bus0.busy};
  assign obs_done  = {bus1.done,     bus0.done};
  assign obs_ready = {bus1.in_ready, bus0.in_ready};

  sr_tx_ctrl #(.WIDTH(W), .DIV(2)) u_dut_d2 (.clk(clk), .rst(rst), .bus(bus0));
  sr_tx_ctrl #(.WIDTH(W), .DIV(1)) u_dut_d1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Model: t = cycles since accept (0 = idle); frame for t=1..W*D, done at W*D+1.
  int unsigned  t_q  [2] = '{0, 0};
  logic [W-1:0] mw_q [2] = '{'0, '0};
  logic [W-1:0] sb0 [$];
  logic [W-1:0] sb1 [$];

  function automatic int unsigned nxt_t(input int k);
    if (t_q[k] == 0) return (drv_valid[k] && !drv_abort[k]) ? 1 : 0;
    if (drv_abort[k]) return 0;
    if (t_q[k] == W * div_of(k) + 1) return 0;
    return t_q[k] + 1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q[0] <= 0;
      t_q[1] <= 0;
      sb0.delete();
      sb1.delete();
    end else begin
      t_q[0] <= nxt_t(0);
      t_q[1] <= nxt_t(1);
      if (t_q[0] == 0 && drv_valid[0] && !drv_abort[0]) begin
        mw_q[0] <= drv_data[0];
        sb0.push_back(drv_data[0]);
      end
      if (t_q[0] != 0 && drv_abort[0]) sb0.delete();
      if (t_q[1] == 0 && drv_valid[1] && !drv_abort[1]) begin
        mw_q[1] <= drv_data[1];
        sb1.push_back(drv_data[1]);
      end
      if (t_q[1] != 0 && drv_abort[1]) sb1.delete();
    end
  end

  logic smp [2][64];
  int   cnt [2] = '{0, 0};

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int unsigned  d;
      int unsigned  t;
      int           idx;
      logic         ef, eso, ed, eb, er;
      logic [W-1:0] w, gw, ew;
      d   = div_of(k);
      t   = t_q[k];
      w   = mw_q[k];
      ef  = (t >= 1) && (t <= W * d);
      idx = ef ? int'(W - 1 - (t - 1) / d) : 0;
      eso = ef ? w[idx] : 1'b0;
      ed  = (t == W * d + 1);
      eb  = (t != 0);
      er  = (t == 0) && !drv_abort[k];
      chk_eq($sformatf("dut%0d_so", k),       32'(obs_so[k]),    32'(eso));
      chk_eq($sformatf("dut%0d_frame", k),    32'(obs_frame[k]), 32'(ef));
      chk_eq($sformatf("dut%0d_busy", k),     32'(obs_busy[k]),  32'(eb));
      chk_eq($sformatf("dut%0d_done", k),     32'(obs_done[k]),  32'(ed));
      chk_eq($sformatf("dut%0d_in_ready", k), 32'(obs_ready[k]), 32'(er));
      if (obs_done[k]) begin
        chk_eq($sformatf("dut%0d_bit_cycles", k), 32'(cnt[k]), 32'(W * d));
        gw = '0;
        for (int i = 0; i < int'(W); i++) gw[W-1-i] = smp[k][i*int'(d)];
        if (k == 0 && sb0.size() == 0) chk_eq("dut0_sb_pending", 32'(0), 32'(1));
        else if (k == 1 && sb1.size() == 0) chk_eq("dut1_sb_pending", 32'(0), 32'(1));
        else begin
          ew = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          chk_eq($sformatf("dut%0d_word", k), 32'(gw), 32'(ew));
        end
        cnt[k] = 0;
      end else if (obs_frame[k]) begin
        if (cnt[k] < 64) smp[k][cnt[k]] = obs_so[k];
        cnt[k]++;
      end else begin
        cnt[k] = 0;
      end
    end
  endtask

  // Called at a falling edge with inputs already set; checks, then waits one cycle.
  task automatic step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic send(input int k, input logic [W-1:0] data);
    drv_data[k]  = data;
    drv_valid[k] = 1'b1;
    step();
    drv_valid[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    drv_data[0] = '0;
    drv_data[1] = '0;
    @(negedge clk);

    // Reset held, then released with no traffic
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();

    // Basic frame, DIV=2
    send(0, 5'b10110);
    repeat (14) step();

    // DIV=1 frame
    send(1, 5'b01011);
    repeat (8) step();

    // Back-to-back with valid held: second word accepted at the first legal edge
    drv_data[0]  = 5'h1F;
    drv_valid[0] = 1'b1;
    step();
    drv_data[0]  = 5'h00;
    repeat (12) step();
    drv_valid[0] = 1'b0;
    repeat (14) step();

    // Abort during the third bit, then a clean frame
    send(0, 5'b11111);
    repeat (4) step();
    drv_abort[0] = 1'b1;
    step();
    drv_abort[0] = 1'b0;
    repeat (3) step();
    send(0, 5'b10011);
    repeat (14) step();

    // Asynchronous reset in the middle of a frame
    send(1, 5'b11101);
    repeat (2) step();
    #2 rst = 1'b0;
    #1;
    chk_eq("rst_mid_so",       32'(bus1.so),       32'(0));
    chk_eq("rst_mid_frame",    32'(bus1.frame),    32'(0));
    chk_eq("rst_mid_busy",     32'(bus1.busy),     32'(0));
    chk_eq("rst_mid_done",     32'(bus1.done),     32'(0));
    chk_eq("rst_mid_in_ready", 32'(bus1.in_ready), 32'(1));
    @(negedge clk);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();

    // valid and abort together in IDLE: nothing accepted
    drv_data[0]  = 5'h15;
    drv_valid[0] = 1'b1;
    drv_abort[0] = 1'b1;
    repeat (4) step();
    drv_valid[0] = 1'b0;
    drv_abort[0] = 1'b0;
    repeat (4) step();

    chk_eq("dut0_sb_drained", 32'(sb0.size()), 32'(0));
    chk_eq("dut1_sb_drained", 32'(sb1.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
